// File: rtl/panda_pcomp_gen2.sv
// panda_pcomp_gen2: second-generation position-compare pulse generator.
// A train of pulses is generated as a signed position crosses a sequence of
// compare points (START, START+-STEP, ...). Each pulse lasts WIDTH position units.
// The direction is positive, negative, or latched at the first pre-arm crossing.
// Configuration errors and target overflows raise a sticky err_o.
// Optional macro PANDA_PCOMP_GEN2_COUNT_EN adds a cnt_o port. cnt_o gives the
// number of pulses emitted since the last arm.
module panda_pcomp_gen2 #(
  parameter int POSN_WIDTH = 32,
  parameter int NUM_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic [POSN_WIDTH-1:0] posn_i,
  input  logic [POSN_WIDTH-1:0] START,
  input  logic [POSN_WIDTH-1:0] STEP,
  input  logic [POSN_WIDTH-1:0] WIDTH,
  input  logic [NUM_WIDTH-1:0]  NUM,
  input  logic                  RELATIVE,
  input  logic [1:0]            DIR,
  input  logic [POSN_WIDTH-1:0] DELTAP,
  output logic                  act_o,
  output logic                  pulse_o,
`ifdef PANDA_PCOMP_GEN2_COUNT_EN
  output logic [NUM_WIDTH-1:0]  cnt_o,
`endif
  output logic                  err_o
);

  // Two guard bits let target arithmetic run without wrapping, so an
  // out-of-range target can be detected rather than silently aliased.
  localparam int XW = POSN_WIDTH + 2;
  localparam logic [NUM_WIDTH-1:0] CNT_ONE = {{(NUM_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREARM   = 3'd1,
    ST_WAIT_PT  = 3'd2,
    ST_PULSE_HI = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  // True when an extended value is representable in POSN_WIDTH signed bits.
  function automatic logic fits_posn(input logic [XW-1:0] v);
    return (v[XW-1:POSN_WIDTH-1] == {3{v[POSN_WIDTH-1]}});
  endfunction

  state_t                   state_q, state_d;
  logic                     en_q;
  logic                     act_q, act_d;
  logic                     pulse_q, pulse_d;
  logic                     err_q, err_d;
  logic signed [XW-1:0]     tgt_q, tgt_d;
  logic signed [XW-1:0]     edge_q, edge_d;
  logic [POSN_WIDTH-1:0]    step_q, step_d;
  logic [POSN_WIDTH-1:0]    width_q, width_d;
  logic [POSN_WIDTH-1:0]    deltap_q, deltap_d;
  logic [NUM_WIDTH-1:0]     num_q, num_d;
  logic [1:0]               dir_q, dir_d;
  logic                     neg_q, neg_d;
  logic [NUM_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     tovf_q, tovf_d;

  logic                     rise_s, fall_s;
  logic signed [XW-1:0]     posn_x_s, start_x_s, origin_x_s, arm_tgt_s;
  logic signed [XW-1:0]     step_x_s, width_x_s, deltap_x_s;
  logic signed [XW-1:0]     next_tgt_s, next_edge_s, pre_lo_s, pre_hi_s;
  logic                     cfg_err_s;
  logic                     reached_tgt_s, reached_edge_s, passed_next_s;
  logic                     below_s, above_s;
  logic [NUM_WIDTH-1:0]     cnt_inc_s;
  logic                     last_pulse_s, done_s;

  assign rise_s     = enable_i & ~en_q;
  assign fall_s     = ~enable_i & en_q;

  assign posn_x_s   = {{2{posn_i[POSN_WIDTH-1]}}, posn_i};
  assign start_x_s  = {{2{START[POSN_WIDTH-1]}}, START};
  assign origin_x_s = RELATIVE ? posn_x_s : {XW{1'b0}};
  assign arm_tgt_s  = origin_x_s + start_x_s;

  assign step_x_s   = {2'b00, step_q};
  assign width_x_s  = {2'b00, width_q};
  assign deltap_x_s = {2'b00, deltap_q};

  assign cfg_err_s  = (WIDTH == {POSN_WIDTH{1'b0}}) ||
                      ((STEP == {POSN_WIDTH{1'b0}}) && (NUM != CNT_ONE)) ||
                      ((STEP != {POSN_WIDTH{1'b0}}) && (WIDTH >= STEP)) ||
                      (DIR == 2'd3);

  // Pre-arm thresholds: the position must first be DELTAP behind START.
  assign pre_lo_s   = tgt_q - deltap_x_s;
  assign pre_hi_s   = tgt_q + deltap_x_s;
  assign below_s    = (posn_x_s <= pre_lo_s);
  assign above_s    = (posn_x_s >= pre_hi_s);

  // Direction-aware compare results, i.e. s*(posn - x) >= 0.
  assign next_tgt_s     = neg_q ? (tgt_q - step_x_s)  : (tgt_q + step_x_s);
  assign next_edge_s    = neg_q ? (tgt_q - width_x_s) : (tgt_q + width_x_s);
  assign reached_tgt_s  = neg_q ? (posn_x_s <= tgt_q)      : (posn_x_s >= tgt_q);
  assign reached_edge_s = neg_q ? (posn_x_s <= edge_q)     : (posn_x_s >= edge_q);
  assign passed_next_s  = neg_q ? (posn_x_s <= next_tgt_s) : (posn_x_s >= next_tgt_s);

  // Saturating count; only NUM=0 can actually drive it to the ceiling.
  assign cnt_inc_s    = (cnt_q == {NUM_WIDTH{1'b1}}) ? cnt_q : (cnt_q + CNT_ONE);
  assign last_pulse_s = (num_q != {NUM_WIDTH{1'b0}}) && (cnt_inc_s == num_q);
  assign done_s       = (num_q != {NUM_WIDTH{1'b0}}) && (cnt_q == num_q);

  // State, configuration snapshot and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      act_q    <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= 1'b0;
      tgt_q    <= {XW{1'b0}};
      edge_q   <= {XW{1'b0}};
      step_q   <= {POSN_WIDTH{1'b0}};
      width_q  <= {POSN_WIDTH{1'b0}};
      deltap_q <= {POSN_WIDTH{1'b0}};
      num_q    <= {NUM_WIDTH{1'b0}};
      dir_q    <= 2'd0;
      neg_q    <= 1'b0;
      cnt_q    <= {NUM_WIDTH{1'b0}};
      tovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= enable_i;
      act_q    <= act_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
      tgt_q    <= tgt_d;
      edge_q   <= edge_d;
      step_q   <= step_d;
      width_q  <= width_d;
      deltap_q <= deltap_d;
      num_q    <= num_d;
      dir_q    <= dir_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      tovf_q   <= tovf_d;
    end
  end

  // Next-state and next-output logic for the compare sequencer.
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    pulse_d  = pulse_q;
    err_d    = err_q;
    tgt_d    = tgt_q;
    edge_d   = edge_q;
    step_d   = step_q;
    width_d  = width_q;
    deltap_d = deltap_q;
    num_d    = num_q;
    dir_d    = dir_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    tovf_d   = tovf_q;

    case (state_q)
      ST_IDLE: begin
        act_d   = 1'b0;
        pulse_d = 1'b0;
        if (rise_s) begin
          err_d    = 1'b0;
          step_d   = STEP;
          width_d  = WIDTH;
          deltap_d = DELTAP;
          num_d    = NUM;
          dir_d    = DIR;
          neg_d    = (DIR == 2'd1);
          tgt_d    = arm_tgt_s;
          cnt_d    = {NUM_WIDTH{1'b0}};
          tovf_d   = 1'b0;
          if (cfg_err_s || !fits_posn(arm_tgt_s)) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            act_d   = 1'b1;
            state_d = ST_PREARM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PREARM: begin
        if (fall_s) begin
          act_d   = 1'b0;
          pulse_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          case (dir_q)
            2'd0: begin
              if (below_s) begin
                neg_d   = 1'b0;
                state_d = ST_WAIT_PT;
              end else begin
                state_d = ST_PREARM;
              end
            end
            2'd1: begin
              if (above_s) begin
                neg_d   = 1'b1;
                state_d = ST_WAIT_PT;
              end else begin
                state_d = ST_PREARM;
              end
            end
            2'd2: begin
              // Positive wins when both thresholds coincide (DELTAP=0).
              if (below_s) begin
                neg_d   = 1'b0;
                state_d = ST_WAIT_PT;
              end else if (above_s) begin
                neg_d   = 1'b1;
                state_d = ST_WAIT_PT;
              end else begin
                state_d = ST_PREARM;
              end
            end
            default: begin
              act_d   = 1'b0;
              err_d   = 1'b1;
              state_d = ST_ERROR;
            end
          endcase
        end
      end

      ST_WAIT_PT: begin
        if (fall_s) begin
          act_d   = 1'b0;
          pulse_d = 1'b0;
          state_d = ST_IDLE;
        end else if (reached_tgt_s) begin
          if (!fits_posn(next_edge_s) || (!last_pulse_s && passed_next_s)) begin
            act_d   = 1'b0;
            pulse_d = 1'b0;
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            // An out-of-range next target only matters if another pulse follows.
            pulse_d = 1'b1;
            cnt_d   = cnt_inc_s;
            edge_d  = next_edge_s;
            tgt_d   = next_tgt_s;
            tovf_d  = !fits_posn(next_tgt_s);
            state_d = ST_PULSE_HI;
          end
        end else begin
          state_d = ST_WAIT_PT;
        end
      end

      ST_PULSE_HI: begin
        if (fall_s) begin
          act_d   = 1'b0;
          pulse_d = 1'b0;
          state_d = ST_IDLE;
        end else if (reached_edge_s) begin
          pulse_d = 1'b0;
          if (done_s) begin
            act_d   = 1'b0;
            state_d = ST_DONE;
          end else if (reached_tgt_s || tovf_q) begin
            act_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            state_d = ST_WAIT_PT;
          end
        end else begin
          state_d = ST_PULSE_HI;
        end
      end

      ST_DONE: begin
        act_d   = 1'b0;
        pulse_d = 1'b0;
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_ERROR: begin
        act_d   = 1'b0;
        pulse_d = 1'b0;
        err_d   = 1'b1;
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERROR;
        end
      end

      default: begin
        act_d   = 1'b0;
        pulse_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign act_o   = act_q;
  assign pulse_o = pulse_q;
  assign err_o   = err_q;
`ifdef PANDA_PCOMP_GEN2_COUNT_EN
  assign cnt_o   = cnt_q;
`endif

endmodule

// File: tb/tb_panda_pcomp_gen2.sv
// Directed self-checking bench for panda_pcomp_gen2.
// It uses a 32-bit instance and a 16-bit instance for the overflow case.
module tb_panda_pcomp_gen2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] posn;
  logic [31:0] start, step, width, num, deltap;
  logic        rel;
  logic [1:0]  dir;
  logic        act, pulse, err;

  logic        en_b;
  logic [15:0] posn_b, start_b, step_b, width_b, deltap_b;
  logic [31:0] num_b;
  logic        act_b, pulse_b, err_b;

  int checks   = 0;
  int failures = 0;

`ifdef PANDA_PCOMP_GEN2_COUNT_EN
  logic [31:0] cnt, cnt_b;
`endif

  assign posn_b = posn[15:0];

  always #5 clk = ~clk;

  panda_pcomp_gen2 #(.POSN_WIDTH(32), .NUM_WIDTH(32)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en), .posn_i(posn),
    .START(start), .STEP(step), .WIDTH(width), .NUM(num),
    .RELATIVE(rel), .DIR(dir), .DELTAP(deltap),
    .act_o(act), .pulse_o(pulse),
`ifdef PANDA_PCOMP_GEN2_COUNT_EN
    .cnt_o(cnt),
`endif
    .err_o(err)
  );

  panda_pcomp_gen2 #(.POSN_WIDTH(16), .NUM_WIDTH(32)) dut16 (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en_b), .posn_i(posn_b),
    .START(start_b), .STEP(step_b), .WIDTH(width_b), .NUM(num_b),
    .RELATIVE(1'b0), .DIR(2'd0), .DELTAP(deltap_b),
    .act_o(act_b), .pulse_o(pulse_b),
`ifdef PANDA_PCOMP_GEN2_COUNT_EN
    .cnt_o(cnt_b),
`endif
    .err_o(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic a, input logic p, input logic e);
    chk({tag, ".act"}, {31'd0, act}, {31'd0, a});
    chk({tag, ".pulse"}, {31'd0, pulse}, {31'd0, p});
    chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
  endtask

  // Present one position sample and let it be clocked in.
  task automatic set_posn(input int v);
    posn = v;
    @(posedge clk);
    #1;
  endtask

  task automatic ramp(input int a, input int b);
    if (a <= b) begin
      for (int v = a; v <= b; v++) set_posn(v);
    end else begin
      for (int v = a; v >= b; v--) set_posn(v);
    end
  endtask

  task automatic cfg(input int s, input int st, input int w, input int n,
                     input logic r, input logic [1:0] d, input int dp);
    start = s; step = st; width = w; num = n; rel = r; dir = d; deltap = dp;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; en_b = 1'b0; posn = 32'd0;
    cfg(0, 10, 5, 1, 1'b0, 2'd0, 0);
    start_b = 16'd32760; step_b = 16'd10; width_b = 16'd5; num_b = 32'd0; deltap_b = 16'd0;
    set_posn(0);
    set_posn(0);
    chk3("reset", 1'b0, 1'b0, 1'b0);
    chk("reset16.act", {31'd0, act_b}, 32'd0);
    rst_n = 1'b1;
    set_posn(0);

    // 1: positive direction, three pulses
    cfg(100, 50, 10, 3, 1'b0, 2'd0, 20);
    en = 1'b1;
    set_posn(0);
    chk3("t1.arm", 1'b1, 1'b0, 1'b0);
    ramp(1, 99);
    chk3("t1.p99", 1'b1, 1'b0, 1'b0);
    set_posn(100);   chk3("t1.p100", 1'b1, 1'b1, 1'b0);
    ramp(101, 109);  chk3("t1.p109", 1'b1, 1'b1, 1'b0);
    set_posn(110);   chk3("t1.p110", 1'b1, 1'b0, 1'b0);
    ramp(111, 149);  chk3("t1.p149", 1'b1, 1'b0, 1'b0);
    set_posn(150);   chk3("t1.p150", 1'b1, 1'b1, 1'b0);
    ramp(151, 160);  chk3("t1.p160", 1'b1, 1'b0, 1'b0);
    ramp(161, 200);  chk3("t1.p200", 1'b1, 1'b1, 1'b0);
    ramp(201, 209);  chk3("t1.p209", 1'b1, 1'b1, 1'b0);
    set_posn(210);   chk3("t1.p210", 1'b0, 1'b0, 1'b0);
`ifdef PANDA_PCOMP_GEN2_COUNT_EN
    chk("t1.cnt", cnt, 32'd3);
`endif
    ramp(211, 260);  chk3("t1.after", 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    set_posn(260);

    // 2: relative start, negative direction
    cfg(-100, 25, 5, 2, 1'b1, 2'd1, 0);
    en = 1'b1;
    set_posn(1000);  chk3("t2.arm", 1'b1, 1'b0, 1'b0);
    ramp(999, 901);  chk3("t2.p901", 1'b1, 1'b0, 1'b0);
    set_posn(900);   chk3("t2.p900", 1'b1, 1'b1, 1'b0);
    ramp(899, 896);  chk3("t2.p896", 1'b1, 1'b1, 1'b0);
    set_posn(895);   chk3("t2.p895", 1'b1, 1'b0, 1'b0);
    ramp(894, 876);  chk3("t2.p876", 1'b1, 1'b0, 1'b0);
    set_posn(875);   chk3("t2.p875", 1'b1, 1'b1, 1'b0);
    ramp(874, 871);  chk3("t2.p871", 1'b1, 1'b1, 1'b0);
    set_posn(870);   chk3("t2.p870", 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    set_posn(870);

    // 3: either direction, latched negative from above
    cfg(0, 20, 5, 1, 1'b0, 2'd2, 10);
    en = 1'b1;
    set_posn(50);    chk3("t3.arm", 1'b1, 1'b0, 1'b0);
    ramp(49, 25);    chk3("t3.p25", 1'b1, 1'b0, 1'b0);
    ramp(24, 1);     chk3("t3.p1", 1'b1, 1'b0, 1'b0);
    set_posn(0);     chk3("t3.p0", 1'b1, 1'b1, 1'b0);
    ramp(-1, -4);    chk3("t3.pm4", 1'b1, 1'b1, 1'b0);
    set_posn(-5);    chk3("t3.pm5", 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    set_posn(-5);

    // 3b: either direction, both thresholds on the same sample -> positive
    cfg(0, 20, 5, 1, 1'b0, 2'd2, 0);
    en = 1'b1;
    set_posn(0);
    set_posn(0);
    set_posn(0);     chk3("t3b.p0", 1'b1, 1'b1, 1'b0);
    set_posn(5);     chk3("t3b.p5", 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    set_posn(5);

    // 4: skipped compare point
    cfg(100, 10, 5, 0, 1'b0, 2'd0, 0);
    en = 1'b1;
    set_posn(0);
    ramp(1, 95);     chk3("t4.p95", 1'b1, 1'b0, 1'b0);
    set_posn(120);   chk3("t4.jump", 1'b0, 1'b0, 1'b1);
    ramp(121, 125);  chk3("t4.hold", 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    set_posn(125);   chk3("t4.dis", 1'b0, 1'b0, 1'b1);
    set_posn(125);   chk3("t4.idle", 1'b0, 1'b0, 1'b1);
    cfg(200, 10, 5, 0, 1'b0, 2'd0, 0);
    en = 1'b1;
    set_posn(125);   chk3("t4.rearm", 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    set_posn(125);   chk3("t4.fall", 1'b0, 1'b0, 1'b0);

    // 5: configuration errors
    cfg(100, 50, 50, 0, 1'b0, 2'd0, 0);
    en = 1'b1;
    set_posn(0);     chk3("t5.w_ge_s", 1'b0, 1'b0, 1'b1);
    set_posn(0);     chk3("t5.w_ge_s2", 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    set_posn(0);
    cfg(100, 50, 10, 0, 1'b0, 2'd3, 0);
    en = 1'b1;
    set_posn(0);     chk3("t5.dir3", 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    set_posn(0);

    // 5b: reset in the middle of a pulse
    cfg(100, 50, 10, 3, 1'b0, 2'd0, 20);
    en = 1'b1;
    set_posn(0);
    ramp(1, 100);    chk3("t5b.pulse", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    set_posn(101);   chk3("t5b.rst", 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    rst_n = 1'b1;
    set_posn(0);

    // 6: 16-bit instance, next target overflows past 32767
    en_b = 1'b1;
    set_posn(32700);
    chk("t6.arm", {31'd0, act_b}, 32'd1);
    ramp(32701, 32759);
    chk("t6.p32759", {31'd0, pulse_b}, 32'd0);
    set_posn(32760);
    chk("t6.p32760", {31'd0, pulse_b}, 32'd1);
    chk("t6.p32760.err", {31'd0, err_b}, 32'd0);
    ramp(32761, 32764);
    chk("t6.p32764", {31'd0, pulse_b}, 32'd1);
    set_posn(32765);
    chk("t6.ovf.err", {31'd0, err_b}, 32'd1);
    chk("t6.ovf.pulse", {31'd0, pulse_b}, 32'd0);
    chk("t6.ovf.act", {31'd0, act_b}, 32'd0);
    en_b = 1'b0;
    set_posn(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
